rr_decoder_arbiter: RTL and testbench

RR_DECODER_ARBITER -- requirements
Module: rr_decoder_arbiter

---
 rtl/rr_decoder_arbiter.sv | 144 ++++++++++++++
 tb/tb_rr_decoder_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/rr_decoder_arbiter.sv
// Round-robin arbiter that owns a shared 1-to-4 decoder path.
// Two-state FSM (idle/grant) with registered outputs; the last owner gets
// lowest priority next round.
// Optional macro ARB_TIMEOUT_EN adds a hold counter that forces release after
// HOLD_MAX grant cycles and pulses timeout; without it timeout is tied low.
module rr_decoder_arbiter #(
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [1:0] sel,
  output logic [3:0] grant,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e     r_state, w_state_d;
  logic [1:0] r_ptr, w_ptr_d;
  logic [1:0] r_sel, w_sel_d;
  logic [3:0] r_grant, w_grant_d;
  logic       r_busy, w_busy_d;
  logic       r_timeout, w_timeout_d;
  logic [1:0] w_winner;
  logic [1:0] w_idx;
  logic       w_found;
  logic       w_expire;
  logic       w_release;

  // Reject out-of-range hold lengths at elaboration.
  if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_hold_max
    $error("HOLD_MAX must be in 2..255");
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HoldLast = 8'(HOLD_MAX - 1);

  logic [7:0] r_hold_cnt, w_hold_cnt_d;

  // Counter is 0 in the first grant cycle, so it reads HOLD_MAX-1 in the last allowed one.
  assign w_expire = (r_state == StGrant) && (r_hold_cnt == HoldLast);

  // Hold counter next state: count while granted, clear otherwise.
  always_comb begin
    w_hold_cnt_d = '0;
    if (r_state == StGrant && !w_release) begin
      w_hold_cnt_d = r_hold_cnt + 8'd1;
    end
  end

  // Hold counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_cnt <= '0;
    end else begin
      r_hold_cnt <= w_hold_cnt_d;
    end
  end
`else
  assign w_expire = 1'b0;
`endif

  assign w_release = done | ~req[r_sel] | w_expire;

  // Winner: first set request scanning upward from r_ptr with wrap.
  always_comb begin
    w_winner = r_ptr;
    w_found  = 1'b0;
    w_idx    = r_ptr;
    for (int i = 0; i < 4; i++) begin
      w_idx = r_ptr + 2'(i);
      if (!w_found && req[w_idx]) begin
        w_winner = w_idx;
        w_found  = 1'b1;
      end
    end
  end

  // FSM next state and registered-output next values.
  always_comb begin
    w_state_d   = r_state;
    w_ptr_d     = r_ptr;
    w_sel_d     = r_sel;
    w_grant_d   = r_grant;
    w_busy_d    = r_busy;
    w_timeout_d = 1'b0;
    unique case (r_state)
      StIdle: begin
        // done is ignored here; sel keeps its last value.
        w_grant_d = 4'b0000;
        w_busy_d  = 1'b0;
        if (|req) begin
          w_state_d = StGrant;
          w_sel_d   = w_winner;
          w_grant_d = 4'b0001 << w_winner;
          w_busy_d  = 1'b1;
        end
      end
      StGrant: begin
        // Release always returns to idle, so a re-request costs one dead cycle.
        if (w_release) begin
          w_state_d   = StIdle;
          w_grant_d   = 4'b0000;
          w_busy_d    = 1'b0;
          w_ptr_d     = r_sel + 2'd1;
          w_timeout_d = w_expire & ~done & req[r_sel];
        end
      end
      default: begin
        w_state_d = StIdle;
        w_grant_d = 4'b0000;
        w_busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_ptr     <= 2'b00;
      r_sel     <= 2'b00;
      r_grant   <= 4'b0000;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_ptr     <= w_ptr_d;
      r_sel     <= w_sel_d;
      r_grant   <= w_grant_d;
      r_busy    <= w_busy_d;
      r_timeout <= w_timeout_d;
    end
  end

  assign sel     = r_sel;
  assign grant   = r_grant;
  assign busy    = r_busy;
  assign timeout = r_timeout;

endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// Directed bench for rr_decoder_arbiter: reset, rotation, stability,
// withdrawal, async reset mid-grant and hold-length behaviour
// (ARB_TIMEOUT_EN selects which hold behaviour is expected).
module tb_rr_decoder_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] req = 4'b0000;
  logic       done = 1'b0;
  logic [1:0] sel;
  logic [3:0] grant;
  logic       busy;
  logic       timeout;

  int checks = 0;
  int failures = 0;

  rr_decoder_arbiter #(
    .HOLD_MAX(8)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .done   (done),
    .sel    (sel),
    .grant  (grant),
    .busy   (busy),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] g, input logic [1:0] s,
                         input logic b);
    chk({tag, ".grant"}, {4'b0, grant}, {4'b0, g});
    chk({tag, ".sel"}, {6'b0, sel}, {6'b0, s});
    chk({tag, ".busy"}, {7'b0, busy}, {7'b0, b});
  endtask

  // Structural invariants every cycle out of reset: one-hot-or-zero grant, grant matches sel.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checks++;
      assert ($onehot0(grant)) else begin
        failures++;
        $error("FAIL onehot: observed %b expected at most one bit", grant);
      end
      if (busy === 1'b1) begin
        checks++;
        assert (grant === (4'b0001 << sel)) else begin
          failures++;
          $error("FAIL decode: observed %b expected %b", grant, 4'b0001 << sel);
        end
      end
    end
  end

  logic [3:0] exp_seq [5];
  int         n_hi;

  initial begin
    exp_seq[0] = 4'b0001;
    exp_seq[1] = 4'b0010;
    exp_seq[2] = 4'b0100;
    exp_seq[3] = 4'b1000;
    exp_seq[4] = 4'b0001;

    // Reset state, applied away from any clock edge.
    #1 rst_n = 1'b0;
    #1;
    chk_out("reset", 4'b0000, 2'b00, 1'b0);
    chk("reset.timeout", {7'b0, timeout}, 8'h00);
    step();
    rst_n = 1'b1;

    // Single requester, done in the third grant cycle, then ptr=1 shows via req=0011.
    req = 4'b0001;
    step(); chk_out("a.c1", 4'b0001, 2'b00, 1'b1);
    step(); chk_out("a.c2", 4'b0001, 2'b00, 1'b1);
    step(); chk_out("a.c3", 4'b0001, 2'b00, 1'b1);
    done = 1'b1;
    step(); chk_out("a.dead", 4'b0000, 2'b00, 1'b0);
    done = 1'b0;
    req = 4'b0011;
    step(); chk_out("a.ptr1", 4'b0010, 2'b01, 1'b1);
    req = 4'b0000;
    step(); chk_out("a.idle", 4'b0000, 2'b01, 1'b0);

    // Fresh reset, full rotation with all requesting.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      step(); chk_out("b.c1", exp_seq[k], 2'(k % 4), 1'b1);
      step(); chk_out("b.c2", exp_seq[k], 2'(k % 4), 1'b1);
      done = 1'b1;
      step();
      done = 1'b0;
      chk_out("b.dead", 4'b0000, 2'(k % 4), 1'b0);
    end

    // Owner 2 stays put while other requests appear; ptr then moves to 3.
    req = 4'b0100;
    step(); chk_out("c.own2", 4'b0100, 2'b10, 1'b1);
    req = 4'b1100;
    step(); chk_out("c.stable", 4'b0100, 2'b10, 1'b1);
    done = 1'b1;
    step(); chk_out("c.dead", 4'b0000, 2'b10, 1'b0);
    done = 1'b0;
    step(); chk_out("c.next", 4'b1000, 2'b11, 1'b1);
    req = 4'b0000;
    step(); chk_out("c.wdraw", 4'b0000, 2'b11, 1'b0);

    // Requester 1 withdraws without done; ptr=2 so 0011 picks requester 0.
    req = 4'b0010;
    step(); chk_out("d.own1", 4'b0010, 2'b01, 1'b1);
    req = 4'b0001;
    step(); chk_out("d.drop", 4'b0000, 2'b01, 1'b0);
    req = 4'b0011;
    step(); chk_out("d.scan", 4'b0001, 2'b00, 1'b1);
    req = 4'b0000;
    step(); chk_out("d.idle", 4'b0000, 2'b00, 1'b0);

    // done in idle is ignored: no grant appears and a later request still wins.
    done = 1'b1;
    step(); chk_out("e.doneidle", 4'b0000, 2'b00, 1'b0);
    req = 4'b0100;
    step(); chk_out("e.grant", 4'b0100, 2'b10, 1'b1);
    done = 1'b0;
    step(); chk_out("e.hold", 4'b0100, 2'b10, 1'b1);

    // Async reset mid-grant drops outputs before the next edge.
    #3 rst_n = 1'b0;
    #1;
    chk_out("f.async", 4'b0000, 2'b00, 1'b0);
    step();
    rst_n = 1'b1;
    req = 4'b1010;
    step(); chk_out("f.after", 4'b0010, 2'b01, 1'b1);

    // Hold-length behaviour with a single stuck requester.
    req = 4'b0001;
    step(); chk_out("g.dead", 4'b0000, 2'b01, 1'b0);
    step(); chk_out("g.c1", 4'b0001, 2'b00, 1'b1);
`ifdef ARB_TIMEOUT_EN
    n_hi = 1;
    for (int k = 0; k < 20; k++) begin
      step();
      if (grant !== 4'b0001) break;
      chk("g.to_early", {7'b0, timeout}, 8'h00);
      n_hi++;
    end
    chk("g.hold_len", 8'(n_hi), 8'd8);
    chk("g.to_pulse", {7'b0, timeout}, 8'h01);
    chk_out("g.forced", 4'b0000, 2'b00, 1'b0);
    step();
    chk("g.to_clear", {7'b0, timeout}, 8'h00);
    chk_out("g.regrant", 4'b0001, 2'b00, 1'b1);
`else
    n_hi = 1;
    for (int k = 0; k < 55; k++) begin
      step();
      if (grant === 4'b0001) n_hi++;
      chk("g.no_to", {7'b0, timeout}, 8'h00);
    end
    chk("g.hold_len", 8'(n_hi), 8'd56);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
